// File: rtl/ser_loader.sv
// Serial boot loader: assembles little-endian LEN/ADDR/DATA words from the
// byte receiver and writes each data word to the internal bus.
module ser_loader #(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              rcv_rdy,
    input  logic [7:0]        rcv_data,
    output logic              rcv_done,
    output logic              bus_stb,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_dout,
    input  logic              bus_ack,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] start_addr
);

    // state    | meaning
    // IDLE     | loader disabled, waiting for en
    // GET_LEN  | collecting the 4 bytes of the block length
    // GET_ADDR | collecting the 4 bytes of the block address
    // GET_DATA | collecting the 4 bytes of the next data word
    // WRITE    | bus write in flight, waiting for bus_ack
    // DONE     | terminating block seen, start_addr valid
    // ERROR    | misaligned length or address, loader halted
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_LEN  = 3'd1,
        GET_ADDR = 3'd2,
        GET_DATA = 3'd3,
        WRITE    = 3'd4,
        DONE     = 3'd5,
        ERROR    = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  cnt;
    logic [23:0] asm_q;
    logic [31:0] len_q;
    logic [29:0] remaining;
    logic        pulse_q;
    logic        rx_state;
    logic        accept;
    logic        word_ok;
    logic [31:0] word;

    assign rx_state = (state == GET_LEN) || (state == GET_ADDR) || (state == GET_DATA);
    // The receiver drops rdy on our done pulse, so the cycle after a pulse is blind.
    assign accept   = en && rx_state && rcv_rdy && !pulse_q;
    assign word_ok  = accept && (cnt == 2'd3);
    assign word     = {rcv_data, asm_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: state_nxt = GET_LEN;
                GET_LEN: begin
                    if (word_ok) begin
                        state_nxt = (word[1:0] != 2'b00) ? ERROR : GET_ADDR;
                    end
                end
                GET_ADDR: begin
                    if (word_ok) begin
                        if (word[1:0] != 2'b00) begin
                            state_nxt = ERROR;
                        end else if (len_q == 32'd0) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = GET_DATA;
                        end
                    end
                end
                GET_DATA: begin
                    if (word_ok) begin
                        state_nxt = WRITE;
                    end
                end
                WRITE: begin
                    if (bus_ack) begin
                        state_nxt = (remaining == 30'd1) ? GET_LEN : GET_DATA;
                    end
                end
                DONE:    state_nxt = DONE;
                ERROR:   state_nxt = ERROR;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bus_stb  = (state == WRITE);
        bus_we   = (state == WRITE);
        done     = (state == DONE);
        err      = (state == ERROR);
        rcv_done = pulse_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= 2'd0;
            asm_q      <= 24'd0;
            len_q      <= 32'd0;
            remaining  <= 30'd0;
            pulse_q    <= 1'b0;
            bus_addr   <= '0;
            bus_dout   <= 32'd0;
            start_addr <= '0;
        end else begin
            pulse_q <= accept;
            if (!en) begin
                cnt <= 2'd0;
            end else if (accept) begin
                cnt <= cnt + 2'd1;
                unique case (cnt)
                    2'd0:    asm_q[7:0]   <= rcv_data;
                    2'd1:    asm_q[15:8]  <= rcv_data;
                    2'd2:    asm_q[23:16] <= rcv_data;
                    default: ;
                endcase
            end

            if (word_ok) begin
                unique case (state)
                    GET_LEN: len_q <= word;
                    GET_ADDR: begin
                        if (word[1:0] == 2'b00) begin
                            if (len_q == 32'd0) begin
                                start_addr <= word[ADDR_W-1:0];
                            end else begin
                                bus_addr  <= word[ADDR_W-1:0];
                                remaining <= len_q[31:2];
                            end
                        end
                    end
                    GET_DATA: bus_dout <= word;
                    default: ;
                endcase
            end

            if (en && (state == WRITE) && bus_ack) begin
                bus_addr  <= bus_addr + ADDR_W'(4);
                remaining <= remaining - 30'd1;
            end
        end
    end

endmodule

// File: tb/tb_ser_loader.sv
// Bench for ser_loader: random/directed boot frames, a frame-level reference
// parser, a byte receiver model and a bus slave with programmable ack delay.
module tb_ser_loader;

    localparam int ADDR_W = 24;
    localparam longint AMOD = longint'(1) << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              rcv_rdy;
    logic [7:0]        rcv_data;
    logic              rcv_done;
    logic              bus_stb;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_dout;
    logic              bus_ack;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] start_addr;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]        tx[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    logic              exp_done;
    logic              exp_err;
    logic [ADDR_W-1:0] exp_start;
    int                exp_used;

    always #5 clk = ~clk;

    ser_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rcv_rdy    (rcv_rdy),
        .rcv_data   (rcv_data),
        .rcv_done   (rcv_done),
        .bus_stb    (bus_stb),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_dout   (bus_dout),
        .bus_ack    (bus_ack),
        .done       (done),
        .err        (err),
        .start_addr (start_addr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        tx.push_back(w[7:0]);
        tx.push_back(w[15:8]);
        tx.push_back(w[23:16]);
        tx.push_back(w[31:24]);
    endtask

    function automatic logic [31:0] get_word(input int p);
        return {tx[p+3], tx[p+2], tx[p+1], tx[p]};
    endfunction

    // Frame-level parse of tx: expected writes, final status and bytes consumed.
    task automatic model();
        int p = 0;
        logic [31:0] len;
        logic [31:0] addr;
        longint a;
        exp_addr.delete();
        exp_data.delete();
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        exp_start = '0;
        exp_used  = 0;
        while (p + 4 <= tx.size()) begin
            len = get_word(p);
            if (len % 4 != 0) begin
                exp_err  = 1'b1;
                exp_used = p + 4;
                return;
            end
            if (p + 8 > tx.size()) break;
            addr = get_word(p + 4);
            if (addr % 4 != 0) begin
                exp_err  = 1'b1;
                exp_used = p + 8;
                return;
            end
            if (len == 0) begin
                exp_done  = 1'b1;
                exp_start = addr[ADDR_W-1:0];
                exp_used  = p + 8;
                return;
            end
            p += 8;
            for (int i = 0; i < int'(len / 4); i++) begin
                if (p + 4 > tx.size()) break;
                a = (longint'(addr) + 4 * longint'(i)) % AMOD;
                exp_addr.push_back(a[ADDR_W-1:0]);
                exp_data.push_back(get_word(p));
                p += 4;
            end
        end
        exp_used = p;
    endtask

    task automatic rand_frame();
        int nb;
        int nw;
        tx.delete();
        nb = int'($urandom_range(1, 3));
        for (int b = 0; b < nb; b++) begin
            nw = int'($urandom_range(1, 4));
            push_word(32'(nw * 4));
            push_word($urandom & 32'hFFFF_FFFC);
            for (int w = 0; w < nw; w++) push_word($urandom);
        end
        push_word(32'd0);
        push_word($urandom & 32'hFFFF_FFFC);
    endtask

    task automatic idle(input string name);
        en      = 1'b0;
        rcv_rdy = 1'b0;
        bus_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({name, "_idle_done"}, done, 0);
        check({name, "_idle_err"}, err, 0);
        check({name, "_idle_stb"}, bus_stb, 0);
    endtask

    task automatic run_frame(input string name, input int abort_at, input bit hold_rdy,
                             input int first_delay, input bit rand_delay, input bit rst_in_write);
        int idx = 0;
        int pulses = 0;
        int cyc = 0;
        int gap = 0;
        int fin = 0;
        int wr_i = 0;
        int stb_len = 0;
        int ack_wait = 0;
        int want_len = 1;
        int dup_err = 0;
        int stab_err = 0;
        int wpulse_err = 0;
        int drop_err = 0;
        bit prev_pulse = 1'b0;
        bit in_write = 1'b0;
        logic [ADDR_W-1:0] h_addr = '0;
        logic [31:0] h_data = '0;
        model();
        en = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus_ack) begin
                bus_ack  = 1'b0;
                in_write = 1'b0;
                if (wr_i < exp_addr.size()) begin
                    check({name, "_wr_addr"}, h_addr, exp_addr[wr_i]);
                    check({name, "_wr_data"}, h_data, exp_data[wr_i]);
                    check({name, "_stb_cycles"}, stb_len, want_len);
                end
                wr_i++;
            end
            if (rcv_done) begin
                pulses++;
                idx++;
                if (prev_pulse) dup_err++;
                if (bus_stb && in_write) wpulse_err++;
                rcv_rdy = 1'b0;
                gap = hold_rdy ? 0 : int'($urandom_range(0, 2));
            end
            prev_pulse = rcv_done;
            if (bus_stb) begin
                if (!in_write) begin
                    in_write = 1'b1;
                    stb_len  = 0;
                    h_addr   = bus_addr;
                    h_data   = bus_dout;
                    ack_wait = (wr_i == 0) ? first_delay :
                               (rand_delay ? int'($urandom_range(0, 3)) : 0);
                    want_len = ack_wait + 1;
                end
                stb_len++;
                if (bus_addr !== h_addr || bus_dout !== h_data || bus_we !== 1'b1) stab_err++;
                if (ack_wait == 0) bus_ack = 1'b1;
                else ack_wait--;
            end else if (in_write) begin
                in_write = 1'b0;
                drop_err++;
            end
            if (rst_in_write && bus_stb && stb_len == 2) begin
                #1 rst = 1'b1;
                #1;
                check({name, "_rst_stb"}, bus_stb, 0);
                check({name, "_rst_we"}, bus_we, 0);
                check({name, "_rst_rcv_done"}, rcv_done, 0);
                check({name, "_rst_addr"}, bus_addr, 0);
                check({name, "_rst_start"}, start_addr, 0);
                #1 rst = 1'b0;
                bus_ack = 1'b0;
                rcv_rdy = 1'b0;
                en      = 1'b0;
                return;
            end
            if (abort_at >= 0 && idx == abort_at) begin
                en      = 1'b0;
                rcv_rdy = 1'b0;
                bus_ack = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                check({name, "_abort_stb"}, bus_stb, 0);
                check({name, "_abort_done"}, done, 0);
                check({name, "_abort_err"}, err, 0);
                check({name, "_abort_dup"}, dup_err, 0);
                return;
            end
            if (!rcv_rdy && idx < tx.size()) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    rcv_rdy  = 1'b1;
                    rcv_data = tx[idx];
                end
            end
            if (done || err) fin++;
            if (fin == 12) break;
            if (cyc > 4000) begin
                check({name, "_timeout_cycles"}, cyc, 0);
                break;
            end
        end
        check({name, "_done"}, done, exp_done);
        check({name, "_err"}, err, exp_err);
        if (exp_done) check({name, "_start_addr"}, start_addr, exp_start);
        check({name, "_bytes_consumed"}, pulses, exp_used);
        check({name, "_write_count"}, wr_i, exp_addr.size());
        check({name, "_back_to_back_pulse"}, dup_err, 0);
        check({name, "_bus_unstable"}, stab_err, 0);
        check({name, "_pulse_in_write"}, wpulse_err, 0);
        check({name, "_stb_dropped_no_ack"}, drop_err, 0);
        check({name, "_final_stb"}, bus_stb, 0);
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        rcv_rdy  = 1'b0;
        rcv_data = 8'h00;
        bus_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rcv_done", rcv_done, 0);
        check("reset_stb", bus_stb, 0);
        check("reset_we", bus_we, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_addr", bus_addr, 0);
        check("reset_dout", bus_dout, 0);
        check("reset_start", start_addr, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        tx.delete();
        push_word(32'd8);
        push_word(32'h0000_0100);
        push_word(32'h4433_2211);
        push_word(32'h8877_6655);
        push_word(32'd0);
        push_word(32'h0000_0200);
        run_frame("single", -1, 1'b0, 0, 1'b0, 1'b0);
        check("single_start_const", start_addr, 24'h000200);
        idle("single");

        run_frame("delayed_ack", -1, 1'b1, 3, 1'b0, 1'b0);
        idle("delayed_ack");

        tx.delete();
        tx.push_back(8'h06); tx.push_back(8'h00); tx.push_back(8'h00); tx.push_back(8'h00);
        push_word(32'h0000_0100);
        push_word(32'h1234_5678);
        run_frame("bad_len", -1, 1'b1, 0, 1'b0, 1'b0);
        idle("bad_len");

        tx.delete();
        push_word(32'd4);
        push_word(32'h0000_0102);
        push_word(32'hCAFE_F00D);
        run_frame("bad_addr", -1, 1'b0, 0, 1'b0, 1'b0);
        idle("bad_addr");

        tx.delete();
        push_word(32'd8);
        push_word(32'h00FF_FFFC);
        push_word(32'hDEAD_BEEF);
        push_word(32'h0BAD_CAFE);
        push_word(32'd0);
        push_word(32'h0000_0040);
        run_frame("addr_wrap", -1, 1'b0, 0, 1'b0, 1'b0);
        idle("addr_wrap");

        rand_frame();
        run_frame("rdy_held", -1, 1'b1, 0, 1'b1, 1'b0);
        idle("rdy_held");

        tx.delete();
        push_word(32'd8);
        push_word(32'h0000_1000);
        push_word(32'h1111_1111);
        push_word(32'h2222_2222);
        push_word(32'd0);
        push_word(32'h0000_0000);
        run_frame("abort", 10, 1'b0, 0, 1'b0, 1'b0);
        rand_frame();
        run_frame("after_abort", -1, 1'b0, 0, 1'b1, 1'b0);
        idle("after_abort");

        for (int r = 0; r < 6; r++) begin
            rand_frame();
            run_frame($sformatf("rand%0d", r), -1, r[0], int'($urandom_range(0, 3)), 1'b1, 1'b0);
            idle($sformatf("rand%0d", r));
        end

        rand_frame();
        run_frame("rst_write", -1, 1'b0, 3, 1'b0, 1'b1);
        rand_frame();
        run_frame("after_rst", -1, 1'b0, 0, 1'b1, 1'b0);
        idle("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
